// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: merges ALU results and queued load returns into one registered write port and keeps the load scoreboard.
// Latency: ALU result is written 1 cycle after sampling; a load return is written 2+ cycles after acceptance (ALU always wins).
// Backpressure: ALU never stalls; load returns use valid/ready with mem_ready = !full (no same-cycle pop bypass).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     single-cycle ALU result stream
//   iss_valid/iss_rd              load issue, marks iss_rd pending in the scoreboard
//   mem_valid/mem_ready/mem_rd/mem_data   load return into the DEPTH-entry FIFO
//   qry_rs1/qry_rs2/qry_rd        decode-stage operands; stall if any is pending
//   RFWr/WrDtAdr/WrDt             registered register-file write port
//   pend_cnt                      number of pending load destinations
module rf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic [4:0]  qry_rs1,
    input  logic [4:0]  qry_rs2,
    input  logic [4:0]  qry_rd,
    output logic        stall,
    output logic        RFWr,
    output logic [4:0]  WrDtAdr,
    output logic [31:0] WrDt,
    output logic [5:0]  pend_cnt
);

    logic [4:0]    fifoRd [DEPTH];
    logic [31:0]   fifoDt [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic [31:0]   busy;       // bit 0 is held at zero so x0 never stalls
    logic [31:0]   busyNext;
    logic          wrSrcMem;   // current RF write came from the load FIFO
    logic          fifoFull;
    logic          fifoEmpty;
    logic          push;
    logic          pop;
    logic [4:0]    headRd;
    logic [31:0]   headDt;

    assign fifoFull  = (count == (AW+1)'(DEPTH));
    assign fifoEmpty = (count == '0);
    assign mem_ready = !fifoFull;
    assign push      = mem_valid && !fifoFull;
    assign pop       = !alu_valid && !fifoEmpty;
    assign headRd    = fifoRd[rdPtr];
    assign headDt    = fifoDt[rdPtr];

    assign stall = busy[qry_rs1] | busy[qry_rs2] | busy[qry_rd];

    // A load's pending mark drops on the edge its RF write commits, so a
    // released reader sees the new value. A new issue of the same register
    // on that edge keeps it pending.
    always_comb begin
        busyNext = busy;
        if (RFWr && wrSrcMem) begin
            busyNext[WrDtAdr] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busyNext[iss_rd] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 1; i < 32; i++) begin
            pend_cnt = pend_cnt + 6'(busy[i]);
        end
    end

    // FIFO storage needs no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoRd[wrPtr] <= mem_rd;
            fifoDt[wrPtr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            busy     <= '0;
            RFWr     <= 1'b0;
            WrDtAdr  <= '0;
            WrDt     <= '0;
            wrSrcMem <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && pop) begin
                count <= count - (AW+1)'(1);
            end

            busy <= busyNext;

            // Writes to x0 are dropped but still consume their slot.
            if (alu_valid) begin
                RFWr     <= (alu_rd != 5'd0);
                wrSrcMem <= 1'b0;
                if (alu_rd != 5'd0) begin
                    WrDtAdr <= alu_rd;
                    WrDt    <= alu_data;
                end
            end else if (pop) begin
                RFWr     <= (headRd != 5'd0);
                wrSrcMem <= 1'b1;
                if (headRd != 5'd0) begin
                    WrDtAdr <= headRd;
                    WrDt    <= headDt;
                end
            end else begin
                RFWr <= 1'b0;
            end
        end
    end

    // Protocol checks on the surrounding pipeline.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(iss_valid && (iss_rd != 5'd0) && busy[iss_rd]));
            assert (!(alu_valid && (alu_rd != 5'd0) && busy[alu_rd]));
            assert (!(push && (mem_rd != 5'd0) && !busy[mem_rd]));
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: scoreboard of expected RF writes (cycle, address, data)
// produced by a queue-based reference model; a monitor checks the write port every cycle.
// Directed scenarios first, then randomized traffic with a mid-flight reset, then drain.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  qry_rs1;
    logic [4:0]  qry_rs2;
    logic [4:0]  qry_rd;
    logic        stall;
    logic        RFWr;
    logic [4:0]  WrDtAdr;
    logic [31:0] WrDt;
    logic [5:0]  pend_cnt;

    rf_wb_arbiter #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .qry_rs1(qry_rs1), .qry_rs2(qry_rs2), .qry_rd(qry_rd),
        .stall(stall), .RFWr(RFWr), .WrDtAdr(WrDtAdr), .WrDt(WrDt), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] dt; } wr_t;
    typedef struct { logic [4:0] rd; logic [31:0] dt; } ld_t;

    wr_t        expQ[$];   // expected RF writes in order, with the cycle they must appear
    ld_t        fifoQ[$];  // model of accepted but not yet written loads
    logic [4:0] outQ[$];   // issued loads whose data has not returned
    bit         mBusy[32];
    logic [4:0] lastLoad;  // register of the load write visible this cycle (0 = none)
    bit         lastAcc;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         monOn = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int mPend();
        int n = 0;
        for (int i = 1; i < 32; i++) n += mBusy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [4:0] pickFree(input logic [4:0] excl);
        logic [4:0] r;
        for (int t = 0; t < 12; t++) begin
            r = 5'($urandom_range(1, 31));
            if (!mBusy[r] && r != excl) return r;
        end
        return 5'd0;
    endfunction

    // Inputs are already driven (at a negedge). Check stall, advance the model
    // across the next rising edge, then check the registered status outputs.
    task automatic cycle();
        ld_t        f;
        logic [4:0] clr;
        logic [4:0] newLast;
        bit         acc;
        #1;
        chk("stall", {31'd0, stall},
            {31'd0, mBusy[qry_rs1] | mBusy[qry_rs2] | mBusy[qry_rd]});
        if (rst) begin
            expQ.delete();
            fifoQ.delete();
            outQ.delete();
            for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
            lastLoad = 5'd0;
            lastAcc  = 1'b0;
        end else begin
            acc     = mem_valid && (fifoQ.size() < DEPTH);
            clr     = lastLoad;
            newLast = 5'd0;
            if (alu_valid) begin
                if (alu_rd != 5'd0) expQ.push_back('{cyc + 1, alu_rd, alu_data});
            end else if (fifoQ.size() > 0) begin
                f = fifoQ.pop_front();
                if (f.rd != 5'd0) begin
                    expQ.push_back('{cyc + 1, f.rd, f.dt});
                    newLast = f.rd;
                end
            end
            if (clr != 5'd0) mBusy[clr] = 1'b0;
            if (iss_valid) begin
                if (iss_rd != 5'd0) mBusy[iss_rd] = 1'b1;
                outQ.push_back(iss_rd);
            end
            if (acc) begin
                for (int i = 0; i < outQ.size(); i++) begin
                    if (outQ[i] == mem_rd) begin
                        outQ.delete(i);
                        break;
                    end
                end
                fifoQ.push_back('{mem_rd, mem_data});
            end
            lastLoad = newLast;
            lastAcc  = acc;
        end
        @(posedge clk);
        @(negedge clk);
        chk("pend_cnt", {26'd0, pend_cnt}, 32'(mPend()));
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, fifoQ.size() < DEPTH});
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic rnd(input int aluPct, input int issPct, input int memPct);
        int idx;
        idle();
        qry_rs1 = 5'($urandom_range(0, 31));
        qry_rs2 = 5'($urandom_range(0, 31));
        qry_rd  = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 99) < aluPct) begin
            alu_valid = 1'b1;
            alu_rd    = ($urandom_range(0, 19) == 0) ? 5'd0 : pickFree(5'd0);
            alu_data  = $urandom;
        end
        if ($urandom_range(0, 99) < issPct && outQ.size() < 8) begin
            iss_valid = 1'b1;
            iss_rd    = ($urandom_range(0, 15) == 0) ? 5'd0 : pickFree(alu_valid ? alu_rd : 5'd0);
        end
        if (outQ.size() > 0 && $urandom_range(0, 99) < memPct) begin
            idx       = $urandom_range(0, outQ.size() - 1);
            mem_valid = 1'b1;
            mem_rd    = outQ[idx];
            mem_data  = $urandom;
        end
        cycle();
    endtask

    task automatic drain();
        int n = 0;
        while ((outQ.size() > 0 || fifoQ.size() > 0 || expQ.size() > 0 || mPend() != 0) && n < 300) begin
            idle();
            if (outQ.size() > 0) begin
                mem_valid = 1'b1;
                mem_rd    = outQ[0];
                mem_data  = $urandom;
            end
            cycle();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    // Write-port monitor: every cycle, RFWr must match whether a write is due now.
    logic mWant;
    wr_t  mE;
    always @(negedge clk) begin
        if (monOn) begin
            mWant = (expQ.size() > 0) && (expQ[0].cyc == cyc);
            chk("rfwr", {31'd0, RFWr}, {31'd0, mWant});
            if (mWant) begin
                mE = expQ.pop_front();
                if (RFWr) begin
                    chk("wr_addr", {27'd0, WrDtAdr}, {27'd0, mE.rd});
                    chk("wr_data", WrDt, mE.dt);
                end
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        idle();
        qry_rs1 = '0; qry_rs2 = '0; qry_rd = '0;
        lastLoad = '0;
        lastAcc  = 1'b0;
        for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rfwr", {31'd0, RFWr}, 32'd0);
        chk("rst_addr", {27'd0, WrDtAdr}, 32'd0);
        chk("rst_data", WrDt, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pend", {26'd0, pend_cnt}, 32'd0);
        chk("rst_ready", {31'd0, mem_ready}, 32'd1);
        rst   = 1'b0;
        monOn = 1'b1;

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        cycle();
        idle();
        cycle();
        cycle();

        // Load path with a dependent reader on x7
        qry_rs1 = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        idle();
        cycle();
        cycle();
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEAD;
        cycle();
        idle();
        repeat (4) cycle();
        qry_rs1 = '0;

        // ALU holds off a queued load for x9
        qry_rd = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd9;
        cycle();
        idle();
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'hA0 + 32'(i);
            cycle();
            idle();
        end
        repeat (4) cycle();
        qry_rd = '0;

        // Back-pressure: five loads returned while ALU occupies the port
        for (int i = 0; i < 5; i++) begin
            idle();
            iss_valid = 1'b1; iss_rd = 5'(10 + i);
            cycle();
        end
        k = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            alu_valid = (c < 8);
            alu_rd    = 5'd20;
            alu_data  = 32'hC00 + 32'(c);
            if (k < 5) begin
                mem_valid = 1'b1; mem_rd = 5'(10 + k); mem_data = 32'hB000 + 32'(k);
            end
            cycle();
            if (lastAcc) k++;
        end
        chk("bp_all_accepted", 32'(k), 32'd5);
        drain();

        // x0 handling
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        cycle();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd0;
        cycle();
        idle();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h5678;
        cycle();
        idle();
        repeat (3) cycle();

        // Reset with loads queued and pending
        idle();
        iss_valid = 1'b1; iss_rd = 5'd3;
        cycle();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd4;
        cycle();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h3333;
        cycle();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h21;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h4444;
        cycle();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd22; alu_data = 32'h22;
        qry_rs1 = 5'd3; qry_rs2 = 5'd4;
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (6) cycle();
        qry_rs1 = '0; qry_rs2 = '0;

        // Randomized traffic: light, then ALU-heavy to exercise back-pressure
        repeat (600) rnd(30, 30, 40);
        repeat (600) rnd(90, 40, 60);
        repeat (200) rnd(60, 40, 50);
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (300) rnd(50, 40, 50);

        drain();
        idle();
        repeat (2) cycle();
        chk("final_queue", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
